// File: rtl/alu_seq_if.sv
// Operand/command and result/flag channel between the core and the sequential ALU.
// The core drives the master side; alu_seq sits on the slave side.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   cmd;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rslt;
    logic         do_branch;
    logic         flag_z;
    logic         flag_c;
    logic         flag_n;
    logic         err;

    modport master (
        output in_valid, cmd, in_a, in_b, out_ready,
        input  in_ready, out_valid, rslt, do_branch, flag_z, flag_c, flag_n, err
    );

    modport slave (
        input  in_valid, cmd, in_a, in_b, out_ready,
        output in_ready, out_valid, rslt, do_branch, flag_z, flag_c, flag_n, err
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes; shifts, rotates and multiply
// iterate one bit per cycle, everything else completes in a single cycle.
module alu_seq #(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input logic      clk,
    input logic      reset_n,
    alu_seq_if.slave bus
);
    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5, OP_SLT = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8;
    localparam logic [3:0] OP_ROL = 4'h9, OP_ROR = 4'hA, OP_MUL = 4'hB, OP_PAR = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD, OP_BRA = 4'hE, OP_ILL = 4'hF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nx;
    logic [3:0]     op;
    logic [W-1:0]   work, opnd_a, rslt_q;
    logic [2*W-1:0] prod;
    logic [CW-1:0]  count;
    logic           carry, z_q, c_q, n_q, br_q, err_q;

    logic           accept, is_shift, is_mul, go_busy, last_step;
    logic [W:0]     add_sum, mul_sum;
    logic [W-1:0]   sc_rslt, work_nx, fin_rslt;
    logic           sc_c, sc_br, carry_nx, fin_c;
    logic [2*W-1:0] prod_nx;

    assign accept    = bus.in_valid && (state == IDLE);
    assign is_shift  = (bus.cmd >= OP_SHL) && (bus.cmd <= OP_ROR);
    assign is_mul    = (bus.cmd == OP_MUL);
    assign go_busy   = is_mul || (is_shift && (bus.in_b[SHW-1:0] != '0));
    assign last_step = (count == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = go_busy ? BUSY : DONE;
            BUSY:    if (last_step) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result of every command that finishes straight out of IDLE, including zero-length shifts.
    always_comb begin
        add_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        sc_rslt = '0;
        sc_c    = 1'b0;
        sc_br   = 1'b0;
        case (bus.cmd)
            OP_ADD: begin sc_rslt = add_sum[W-1:0]; sc_c = add_sum[W]; end
            OP_SUB: begin sc_rslt = bus.in_a - bus.in_b; sc_c = (bus.in_a >= bus.in_b); end
            OP_AND: sc_rslt = bus.in_a & bus.in_b;
            OP_OR:  sc_rslt = bus.in_a | bus.in_b;
            OP_XOR: sc_rslt = bus.in_a ^ bus.in_b;
            OP_SLT: sc_rslt = {{(W-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: sc_rslt = bus.in_a;
            OP_PAR: sc_rslt = {{(W-1){1'b0}}, ^bus.in_a};
            OP_BEQ: sc_br = (bus.in_a == bus.in_b);
            OP_BRA: sc_br = 1'b1;
            default: ;
        endcase
    end

    // One iteration step; the final result is taken from the post-step values so DONE follows the last step.
    always_comb begin
        mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd_a} : '0);
        work_nx  = work;
        prod_nx  = prod;
        carry_nx = carry;
        case (op)
            OP_SHL: begin carry_nx = work[W-1]; work_nx = {work[W-2:0], 1'b0}; end
            OP_SHR: begin carry_nx = work[0];   work_nx = {1'b0, work[W-1:1]}; end
            OP_ROL: work_nx = {work[W-2:0], work[W-1]};
            OP_ROR: work_nx = {work[0], work[W-1:1]};
            OP_MUL: prod_nx = {mul_sum, prod[W-1:1]};
            default: ;
        endcase
        fin_rslt = (op == OP_MUL) ? prod_nx[W-1:0]    : work_nx;
        fin_c    = (op == OP_MUL) ? |prod_nx[2*W-1:W] : carry_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op     <= '0;
            work   <= '0;
            opnd_a <= '0;
            prod   <= '0;
            count  <= '0;
            carry  <= 1'b0;
            rslt_q <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            br_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op     <= bus.cmd;
                    work   <= bus.in_a;
                    opnd_a <= bus.in_a;
                    prod   <= {{W{1'b0}}, bus.in_b};
                    carry  <= 1'b0;
                    count  <= is_mul ? CW'(W) : CW'(bus.in_b[SHW-1:0]);
                    err_q  <= (bus.cmd == OP_ILL);
                    if (!go_busy) begin
                        rslt_q <= sc_rslt;
                        c_q    <= sc_c;
                        z_q    <= (sc_rslt == '0);
                        n_q    <= sc_rslt[W-1];
                        br_q   <= sc_br;
                    end
                end
                BUSY: begin
                    work  <= work_nx;
                    prod  <= prod_nx;
                    carry <= carry_nx;
                    count <= count - CW'(1);
                    if (last_step) begin
                        rslt_q <= fin_rslt;
                        c_q    <= fin_c;
                        z_q    <= (fin_rslt == '0);
                        n_q    <= fin_rslt[W-1];
                        br_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.rslt      = rslt_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_n    = n_q;
    assign bus.do_branch = br_q;
    assign bus.err       = err_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Generalised data width. Valid/ready handshakes on both the operand and result sides.
- Iterative shift, rotate and multiply units, one step per cycle.
- Registered condition flags (zero, carry, negative) and a branch-decision output.
- Sits between decode/register-read and writeback. The core stalls on `in_ready`/`out_valid`.

Parameters:
- W, 8: data-path width in bits (≥4, power of two).
- SHW, $clog2(W): width of the shift/rotate amount field, taken from `in_b[SHW-1:0]`.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/command presented
- in_ready  output  1  block can accept; high only in IDLE
- cmd  input  4  operation code, see Behaviour
- in_a  input  W  operand A
- in_b  input  W  operand B / shift amount
- out_valid  output  1  result, flags and branch are valid
- out_ready  input  1  consumer takes the result
- rslt  output  W  result
- do_branch  output  1  branch decision for BEQ/BRA
- flag_z, flag_c, flag_n  output  1 each  zero, carry, negative for the current result
- err  output  1  illegal cmd was issued

Behaviour:
- Reset (async, reset_n=0), from any state:
  - state=IDLE; rslt=0, do_branch=0, flags=0, err=0, out_valid=0; in_ready=1 once reset releases.
  - Reset mid-operation aborts the operation; no result is produced.
- Command codes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SHL, 8 SHR, 9 ROL, A ROR, B MUL, C PAR (reduction XOR of A into bit 0), D BEQ, E BRA, F illegal.
- States:
  - IDLE: accept happens when in_valid && in_ready. Latch cmd, A and B.
    - Single-cycle cmds (0–6, C, D, E, F) → DONE.
    - Shift/rotate → BUSY with count = in_b[SHW-1:0]; count 0 → DONE directly, result = A.
    - MUL → BUSY with count = W.
  - BUSY: one step per cycle, count decrements. Moves to DONE in the cycle after the step where count reaches 1.
    - Shift/rotate step: one bit position.
    - MUL step: shift-add of one multiplier bit into a 2W accumulator.
  - DONE: out_valid=1; rslt, flags, do_branch, err are stable.
    - Held until out_ready=1, then → IDLE.
    - No accept in the same cycle as the handoff.
    - in_valid is ignored outside IDLE.
- Latency from accept edge to out_valid:
  - 1 cycle for single-cycle cmds.
  - 1+n cycles for shift/rotate by n.
  - 1+W cycles for MUL.
- Arithmetic (all results truncated to W bits):
  - ADD: flag_c = carry-out.
  - SUB: flag_c = 1 when A ≥ B unsigned (no borrow).
  - SLT: unsigned; rslt = 1 or 0; flag_c = 0.
  - SHL/SHR: zero fill; flag_c = last bit shifted out (0 when n = 0).
  - ROL/ROR: flag_c = 0.
  - MUL: rslt = low W bits of A*B; flag_c = 1 when the high W bits are nonzero.
  - AND/OR/XOR/PAR/NOP/BEQ/BRA/F: flag_c = 0.
- flag_z = (rslt == 0); flag_n = rslt[W-1]. Both are computed on entry to DONE.
- BEQ: rslt = 0, do_branch = (A == B). BRA: rslt = 0, do_branch = 1. All other cmds: do_branch = 0.
- Illegal (F): rslt = 0, err = 1. err is cleared by the next accepted legal cmd.
- Outputs are registered. rslt, flags, do_branch and err hold their last values in IDLE; only out_valid drops.

Test Plan (W=8):
- ADD A=0xF0, B=0x20 → out_valid 1 cycle after accept; rslt=0x10, flag_c=1, flag_z=0, flag_n=0.
- SUB A=0x05, B=0x07 → rslt=0xFE, flag_c=0, flag_n=1. Then SLT with the same operands → rslt=0x01.
- ROL A=0x81, B=3 → in_ready low for 4 cycles; out_valid at accept+4; rslt=0x0C. SHL A=0x81, B=0 → rslt=0x81 at accept+1, flag_c=0.
- MUL 0x0D×0x13 → rslt=0xF7, flag_c=0 at accept+9. MUL 0x10×0x10 → rslt=0x00, flag_z=1, flag_c=1.
- Backpressure: hold out_ready=0 for 5 cycles during DONE with in_valid=1 → rslt held, in_ready=0, no new accept. Raise out_ready → IDLE, next cmd accepted the following cycle.
- BEQ 0x3C/0x3C → do_branch=1. cmd F → err=1, rslt=0. Assert reset_n=0 mid-MUL → immediate IDLE with all outputs 0, and the next ADD completes correctly.
